// File: rtl/definitions.sv
// rtl/definitions.sv - shared byte type and tape operation codes
package definitions;

    typedef logic [7:0] BYTE;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_INC_PTR  = 3'd1,
        OP_DEC_PTR  = 3'd2,
        OP_INC_DATA = 3'd3,
        OP_DEC_DATA = 3'd4,
        OP_READ     = 3'd5,
        OP_WRITE    = 3'd6,
        OP_CLEAR    = 3'd7
    } tape_op_t;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - tape cell storage: combinational read, clocked write, side read port
module data_mem
    import definitions::*;
(
    input  logic clk,
    input  BYTE  addr,
    input  logic rd_en,
    input  logic wr_en,
    input  BYTE  din,
    output BYTE  dout,
    input  BYTE  dbg_addr,
    output BYTE  dbg_data
);

    BYTE mem_q [0:255];

    // Cell contents are never reset; only explicit writes change them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= din;
        end
    end

    assign dout     = rd_en ? mem_q[addr] : '0;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/tape_ctrl.sv
// rtl/tape_ctrl.sv - tape pointer/cell command engine driving an external byte memory
module tape_ctrl
    import definitions::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  tape_op_t      cmd_op,
    input  BYTE           cmd_data,
    output logic          rsp_valid,
    output BYTE           rsp_data,
    output logic [AW-1:0] ptr,
    output logic          cell_zero,
    output BYTE           memAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output BYTE           memDataIn,
    input  BYTE           memDataOut
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q;
    tape_op_t      op_q;
    BYTE           data_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] clr_cnt_q;
    logic          rsp_valid_q;
    BYTE           rsp_data_q;

    // Control FSM: accept in IDLE, one EXEC cycle per command, CLEAR sweeps every cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            ptr_q       <= '0;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        state_q <= (cmd_op == OP_CLEAR) ? ST_CLEAR : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_q)
                        OP_INC_PTR: ptr_q <= ptr_q + AW'(1);
                        OP_DEC_PTR: ptr_q <= ptr_q - AW'(1);
                        OP_READ: begin
                            rsp_data_q  <= memDataOut;
                            rsp_valid_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    state_q <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == CNT_LAST) begin
                        clr_cnt_q <= '0;
                        ptr_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port: read-modify-write happens within the single EXEC cycle
    always_comb begin
        ReadMem    = 1'b0;
        WriteMem   = 1'b0;
        memAddress = BYTE'(ptr_q);
        memDataIn  = '0;
        case (state_q)
            ST_IDLE: ReadMem = 1'b1;
            ST_EXEC: begin
                case (op_q)
                    OP_INC_DATA: begin
                        ReadMem   = 1'b1;
                        WriteMem  = 1'b1;
                        memDataIn = memDataOut + 8'd1;
                    end
                    OP_DEC_DATA: begin
                        ReadMem   = 1'b1;
                        WriteMem  = 1'b1;
                        memDataIn = memDataOut - 8'd1;
                    end
                    OP_WRITE: begin
                        WriteMem  = 1'b1;
                        memDataIn = data_q;
                    end
                    OP_READ: ReadMem = 1'b1;
                    default: ;
                endcase
            end
            ST_CLEAR: begin
                WriteMem   = 1'b1;
                memAddress = BYTE'(clr_cnt_q);
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign cell_zero = (state_q == ST_IDLE) && (memDataOut == 8'h00);
    assign ptr       = ptr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tape_ctrl.sv
// tb/tb_tape_ctrl.sv - randomized self-checking bench for tape_ctrl with data_mem responder
module tb_tape_ctrl;
    import definitions::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    tape_op_t   cmd_op;
    BYTE        cmd_data;
    logic       rsp_valid;
    BYTE        rsp_data;
    logic [7:0] ptr;
    logic       cell_zero;
    BYTE        memAddress;
    logic       ReadMem;
    logic       WriteMem;
    BYTE        memDataIn;
    BYTE        memDataOut;
    BYTE        dbg_addr;
    BYTE        dbg_data;

    int checks   = 0;
    int failures = 0;

    // reference model of the tape
    int mem_m [256];
    int ptr_m;
    int last_rsp_m;

    tape_ctrl #(.AW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ptr       (ptr),
        .cell_zero (cell_zero),
        .memAddress(memAddress),
        .ReadMem   (ReadMem),
        .WriteMem  (WriteMem),
        .memDataIn (memDataIn),
        .memDataOut(memDataOut)
    );

    data_mem u_mem (
        .clk     (clk),
        .addr    (memAddress),
        .rd_en   (ReadMem),
        .wr_en   (WriteMem),
        .din     (memDataIn),
        .dout    (memDataOut),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns the cell value for reads, -1 otherwise
    function automatic int model_apply(input tape_op_t op, input int d);
        int r;
        r = -1;
        case (op)
            OP_INC_PTR:  ptr_m = (ptr_m + 1) % 256;
            OP_DEC_PTR:  ptr_m = (ptr_m + 255) % 256;
            OP_INC_DATA: mem_m[ptr_m] = (mem_m[ptr_m] + 1) % 256;
            OP_DEC_DATA: mem_m[ptr_m] = (mem_m[ptr_m] + 255) % 256;
            OP_WRITE:    mem_m[ptr_m] = d;
            OP_READ: begin
                r = mem_m[ptr_m];
                last_rsp_m = r;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_ptr", ptr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wmem", WriteMem, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        last_rsp_m = 0;
    endtask

    task automatic offer_and_accept(input tape_op_t op, input BYTE d);
        int w;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic do_cmd(input tape_op_t op, input BYTE d);
        int r;
        offer_and_accept(op, d);
        r = model_apply(op, int'(d));
        @(negedge clk);
        chk("exec_ready", cmd_ready, 0);
        chk("exec_cell_zero", cell_zero, 0);
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        chk("rsp_valid", rsp_valid, (op == OP_READ) ? 1 : 0);
        chk("rsp_data", rsp_data, last_rsp_m);
        chk("ptr", ptr, ptr_m);
        chk("cell_zero", cell_zero, (mem_m[ptr_m] == 0) ? 1 : 0);
        if (op == OP_READ) begin
            @(negedge clk);
            chk("rsp_pulse_end", rsp_valid, 0);
        end
    endtask

    // abort_at < 0 lets the sweep complete; otherwise reset is applied in that CLEAR cycle
    task automatic clear_cmd(input int abort_at);
        int idx;
        offer_and_accept(OP_CLEAR, 8'h00);
        @(negedge clk);
        idx = 0;
        while (!cmd_ready && idx < 400) begin
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_wmem", WriteMem, 0);
                chk("abort_ready", cmd_ready, 1);
                chk("abort_ptr", ptr, 0);
                for (int i = 0; i < abort_at; i++) mem_m[i] = 0;
                ptr_m = 0;
                last_rsp_m = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            idx++;
        end
        chk("clear_cycles", idx, 256);
        for (int i = 0; i < 256; i++) mem_m[i] = 0;
        ptr_m = 0;
        chk("clear_ptr", ptr, 0);
    endtask

    task automatic dump_compare(input string tag);
        for (int i = 0; i < 256; i++) begin
            dbg_addr = BYTE'(i);
            #1;
            chk($sformatf("%s_cell%0d", tag, i), dbg_data, mem_m[i]);
        end
    endtask

    task automatic random_fill();
        for (int i = 0; i < 256; i++) begin
            do_cmd(OP_WRITE, BYTE'($urandom_range(1, 255)));
            do_cmd(OP_INC_PTR, 8'h00);
        end
    endtask

    task automatic b2b(input int n);
        tape_op_t ops[$];
        BYTE      dat[$];
        int accepted, cyc, last_acc, r;
        tape_op_t pool [6];
        pool = '{OP_NOP, OP_INC_PTR, OP_DEC_PTR, OP_INC_DATA, OP_DEC_DATA, OP_WRITE};
        for (int i = 0; i < n; i++) begin
            ops.push_back(pool[$urandom_range(0, 5)]);
            dat.push_back(BYTE'($urandom));
        end
        accepted = 0;
        cyc = 0;
        last_acc = -1;
        while (accepted < n && cyc < 500) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = ops[accepted];
            cmd_data  = dat[accepted];
            if (cmd_ready) begin
                if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, 2);
                last_acc = cyc;
                r = model_apply(ops[accepted], int'(dat[accepted]));
                accepted++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        chk("b2b_count", accepted, n);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_ready", cmd_ready, 1);
        chk("b2b_ptr", ptr, ptr_m);
    endtask

    task automatic reset_in_exec();
        int old_ptr;
        int old_val;
        old_ptr = ptr_m;
        old_val = mem_m[ptr_m];
        offer_and_accept(OP_WRITE, BYTE'((old_val + 1) % 256));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("exec_rst_wmem", WriteMem, 0);
        chk("exec_rst_ptr", ptr, 0);
        @(posedge clk);
        #1;
        chk("exec_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        last_rsp_m = 0;
        dbg_addr = BYTE'(old_ptr);
        #1;
        chk("exec_rst_cell", dbg_data, old_val);
    endtask

    initial begin
        int r;
        tape_op_t op;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_data  = '0;
        dbg_addr  = '0;
        ptr_m      = 0;
        last_rsp_m = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 0;

        apply_reset();
        clear_cmd(-1);
        dump_compare("clr0");

        // three increments then read back
        repeat (3) do_cmd(OP_INC_DATA, 8'h00);
        do_cmd(OP_READ, 8'h00);
        chk("read3", rsp_data, 8'h03);

        // data wrap in both directions
        do_cmd(OP_WRITE, 8'h00);
        do_cmd(OP_DEC_DATA, 8'h00);
        dbg_addr = 8'd0; #1;
        chk("dec_wrap_cell", dbg_data, 8'hFF);
        chk("dec_wrap_zero", cell_zero, 0);
        do_cmd(OP_INC_DATA, 8'h00);
        dbg_addr = 8'd0; #1;
        chk("inc_wrap_cell", dbg_data, 8'h00);
        chk("inc_wrap_zero", cell_zero, 1);

        // pointer wrap
        do_cmd(OP_DEC_PTR, 8'h00);
        chk("ptr_wrap_dn", ptr, 8'd255);
        do_cmd(OP_WRITE, 8'hA5);
        dbg_addr = 8'd255; #1;
        chk("m255", dbg_data, 8'hA5);
        dbg_addr = 8'd0; #1;
        chk("m0_kept", dbg_data, 8'h00);
        do_cmd(OP_INC_PTR, 8'h00);
        chk("ptr_wrap_up", ptr, 8'd0);

        // random command walk
        for (int i = 0; i < 300; i++) begin
            op = tape_op_t'($urandom_range(0, 6));
            do_cmd(op, BYTE'($urandom));
        end
        dump_compare("walk");

        // full clear after random fill
        random_fill();
        clear_cmd(-1);
        dump_compare("clr_full");

        // clear aborted by reset in cycle 100
        random_fill();
        clear_cmd(100);
        chk("abort_idle", cmd_ready, 1);
        chk("abort_ptr_after", ptr, 0);
        dump_compare("clr_abort");

        // back-to-back offers
        do_cmd(OP_INC_PTR, 8'h00);
        b2b(40);
        dump_compare("b2b");

        // reset while a write is pending
        do_cmd(OP_INC_PTR, 8'h00);
        reset_in_exec();
        do_cmd(OP_READ, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tape_ctrl.md
TAPE_CTRL -- requirements
Module: tape_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning the tape address width (tape depth 2**AW cells, pointer width AW).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command offered.
REQ-005 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_op, input, tape_op_t (3), operation code.
REQ-007 SHALL have port cmd_data, input, BYTE, byte for OP_WRITE.
REQ-008 SHALL have port rsp_valid, output, 1, one-cycle pulse carrying an OP_READ result.
REQ-009 SHALL have port rsp_data, output, BYTE, cell value returned by OP_READ.
REQ-010 SHALL have port ptr, output, AW, current data pointer.
REQ-011 SHALL have port cell_zero, output, 1, cell at ptr equals 0; valid only while cmd_ready is high.
REQ-012 SHALL have port memAddress, output, BYTE, memory address.
REQ-013 SHALL have port ReadMem, output, 1, memory read enable; reads are combinational.
REQ-014 SHALL have port WriteMem, output, 1, memory write enable; writes commit on the clk rising edge.
REQ-015 SHALL have port memDataIn, output, BYTE, write data driven to memory.
REQ-016 SHALL have port memDataOut, input, BYTE, read data returned by memory in the same cycle.

Function
REQ-017 SHALL implement states IDLE, EXEC and CLEAR.
REQ-018 In IDLE: cmd_ready=1, memAddress=ptr, ReadMem=1, WriteMem=0, cell_zero=(memDataOut==0).
REQ-019 In IDLE, cmd_valid&&cmd_ready SHALL latch cmd_op and cmd_data and move to EXEC (OP_CLEAR: to CLEAR).
REQ-020 In EXEC and CLEAR: cmd_ready=0, cell_zero=0.
REQ-021 EXEC SHALL last exactly one cycle and then return to IDLE; one command per 2 cycles maximum.
REQ-022 OP_INC_PTR: ptr<=ptr+1 mod 2**AW, 255->0 wrap; no memory write.
REQ-023 OP_DEC_PTR: ptr<=ptr-1 mod 2**AW, 0->255 wrap; no memory write.
REQ-024 OP_INC_DATA: ReadMem=1, WriteMem=1, memAddress=ptr, memDataIn=memDataOut+1 mod 256 (0xFF->0x00).
REQ-025 OP_DEC_DATA: same as REQ-024 with memDataIn=memDataOut-1 mod 256 (0x00->0xFF).
REQ-026 OP_WRITE: WriteMem=1, memAddress=ptr, memDataIn=latched cmd_data.
REQ-027 OP_READ: ReadMem=1, memAddress=ptr; rsp_data<=memDataOut at the end of EXEC; rsp_valid=1 for exactly the following cycle (same cycle as the return to IDLE).
REQ-028 OP_CLEAR: write 0 to addresses 0..2**AW-1 in ascending order, one per cycle (WriteMem=1, ReadMem=0), using an internal counter; after address 2**AW-1, ptr<=0 and return to IDLE.
REQ-029 OP_CLEAR SHALL keep the block in CLEAR for exactly 2**AW cycles.
REQ-030 OP_NOP and undefined opcodes SHALL pass through EXEC with no memory write and no ptr change.
REQ-031 Outside the cases above, WriteMem=0, and memDataIn SHALL still be driven (0) -- never Z.
REQ-032 cmd_valid while cmd_ready=0 SHALL be ignored; the offering side holds it.
REQ-033 rsp_data SHALL hold its last value between reads.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, ptr=0, rsp_valid=0, rsp_data=0, clear counter=0, WriteMem=0.
REQ-035 Reset during CLEAR SHALL abort it, leaving the tape partially cleared; memory contents are never reset by this block.
REQ-036 Reset during EXEC SHALL suppress the pending write and any rsp_valid.

Structure
REQ-037 tape_op_t SHALL live in package definitions: enum with OP_NOP=0, OP_INC_PTR=1, OP_DEC_PTR=2, OP_INC_DATA=3, OP_DEC_DATA=4, OP_READ=5, OP_WRITE=6, OP_CLEAR=7.
REQ-038 The state enum SHALL be local to tape_ctrl, and BYTE SHALL come from definitions.
REQ-039 tape_ctrl SHALL have no sub-module; the bench SHALL pair it with data_mem as the responder.

Verification
REQ-040 Reset, OP_CLEAR, then OP_INC_DATA x3 -> cell 0 = 0x03; OP_READ -> rsp_valid one cycle with rsp_data=0x03.
REQ-041 Cell 0=0x00, OP_DEC_DATA -> cell 0=0xFF and cell_zero=0; then OP_INC_DATA -> cell 0=0x00 and cell_zero=1.
REQ-042 ptr=0, OP_DEC_PTR -> ptr=255; OP_WRITE 0xA5 -> M[255]=0xA5, M[0] unchanged; OP_INC_PTR -> ptr=0.
REQ-043 OP_CLEAR after random fill -> cmd_ready low for exactly 256 cycles, all cells 0, ptr=0.
REQ-044 rst_n asserted at CLEAR cycle 100 -> cells 0..99 are 0, cells 100+ are unchanged, state IDLE, ptr=0.
REQ-045 Back-to-back cmd_valid held high -> commands accepted every 2nd cycle; none lost or duplicated.
